// File: rtl/inst_decoder.sv
// Instruction decoder: registers every decoded field of the instruction word
// with one cycle of latency. It also tracks the datapath phase and the PSUM
// accumulation count, generates the ReLU capture pulse, and keeps sticky
// error flags.
module inst_decoder #(
  parameter int unsigned len_kij = 9,
  parameter int unsigned inst_bw = 35
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [inst_bw-1:0] inst,
  input  logic               ofifo_valid,
  output logic               load_o,
  output logic               execute_o,
  output logic               l0_wr_o,
  output logic               l0_rd_o,
  output logic               ififo_wr_o,
  output logic               ififo_rd_o,
  output logic               ofifo_rd_o,
  output logic               acc_o,
  output logic               bypass_o,
  output logic               xmem_cen_o,
  output logic               xmem_wen_o,
  output logic               pmem_cen_o,
  output logic               pmem_wen_o,
  output logic [10:0]        xmem_addr_o,
  output logic [10:0]        pmem_addr_o,
  output logic [2:0]         phase_o,
  output logic [3:0]         acc_cnt_o,
  output logic               relu_o,
  output logic [3:0]         err_o
);

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ERR_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(15);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(len_kij);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    XWR    = 3'd1,
    L0FILL = 3'd2,
    LOAD   = 3'd3,
    EXEC   = 3'd4,
    DRAIN  = 3'd5,
    ACCUM  = 3'd6
  } phase_e;

  // Instruction fields
  logic              f_bypass, f_acc, f_cen_p, f_wen_p;
  logic              f_cen_x, f_wen_x;
  logic [ADDR_W-1:0] f_addr_p, f_addr_x;
  logic              f_ofifo_rd, f_ififo_wr, f_ififo_rd;
  logic              f_l0_rd, f_l0_wr, f_execute, f_load;

  assign f_bypass   = inst[34];
  assign f_acc      = inst[33];
  assign f_cen_p    = inst[32];
  assign f_wen_p    = inst[31];
  assign f_addr_p   = inst[30:20];
  assign f_cen_x    = inst[19];
  assign f_wen_x    = inst[18];
  assign f_addr_x   = inst[17:7];
  assign f_ofifo_rd = inst[6];
  assign f_ififo_wr = inst[5];
  assign f_ififo_rd = inst[4];
  assign f_l0_rd    = inst[3];
  assign f_l0_wr    = inst[2];
  assign f_execute  = inst[1];
  assign f_load     = inst[0];

  // State and output registers
  logic              load_q, execute_q, l0_wr_q, l0_rd_q;
  logic              ififo_wr_q, ififo_rd_q, ofifo_rd_q, acc_q, bypass_q;
  logic              xmem_cen_q, xmem_wen_q, pmem_cen_q, pmem_wen_q;
  logic [ADDR_W-1:0] xmem_addr_q, pmem_addr_q;
  phase_e            phase_q;
  logic              hold_q;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic              relu_q;
  logic [ERR_W-1:0]  err_q;

  logic              load_d, execute_d, l0_wr_d, l0_rd_d;
  logic              ififo_wr_d, ififo_rd_d, ofifo_rd_d, acc_d, bypass_d;
  logic              xmem_cen_d, xmem_wen_d, pmem_cen_d, pmem_wen_d;
  logic [ADDR_W-1:0] xmem_addr_d, pmem_addr_d;
  phase_e            phase_d;
  logic              hold_d;
  logic [CNT_W-1:0]  acc_cnt_d;
  logic              relu_d;
  logic [ERR_W-1:0]  err_d;

  logic pmem_wr_req, wr_acc_conflict, pmem_wr, pmem_rd, xmem_wr;
  logic acc_inc, acc_fall;

  // Decode, phase selection, accumulation tracking and error capture
  always_comb begin
    load_d      = f_load;
    execute_d   = f_execute;
    l0_wr_d     = f_l0_wr;
    l0_rd_d     = f_l0_rd;
    ififo_wr_d  = f_ififo_wr;
    ififo_rd_d  = f_ififo_rd;
    ofifo_rd_d  = f_ofifo_rd & ofifo_valid;
    acc_d       = f_acc;
    bypass_d    = f_bypass;
    xmem_cen_d  = f_cen_x;
    xmem_wen_d  = f_wen_x;
    xmem_addr_d = f_addr_x;
    pmem_cen_d  = f_cen_p;
    pmem_wen_d  = f_wen_p;
    pmem_addr_d = f_addr_p;
    phase_d     = IDLE;
    hold_d      = 1'b0;
    acc_cnt_d   = acc_cnt_q;
    relu_d      = 1'b0;
    err_d       = err_q;

    pmem_wr_req     = ~f_cen_p & ~f_wen_p;
    wr_acc_conflict = pmem_wr_req & f_acc & ~f_bypass;
    pmem_wr         = pmem_wr_req & ~wr_acc_conflict;
    pmem_rd         = ~f_cen_p & f_wen_p;
    xmem_wr         = ~f_cen_x & ~f_wen_x;
    acc_inc         = f_acc & pmem_rd;
    acc_fall        = acc_q & ~f_acc;

    // A write during accumulation would corrupt PSUMs: suppress the access
    if (wr_acc_conflict) begin
      pmem_cen_d = 1'b1;
      pmem_wen_d = 1'b1;
    end

    // Phase priority; one strobe-less gap keeps the current phase
    if (f_execute) begin
      phase_d = EXEC;
    end else if (f_load) begin
      phase_d = LOAD;
    end else if (f_l0_wr) begin
      phase_d = L0FILL;
    end else if (xmem_wr) begin
      phase_d = XWR;
    end else if (f_ofifo_rd || pmem_wr) begin
      phase_d = DRAIN;
    end else if (f_acc) begin
      phase_d = ACCUM;
    end else if (!hold_q) begin
      phase_d = phase_q;
      hold_d  = 1'b1;
    end

    // End of an accumulation window clears the count and requests capture
    if (acc_fall) begin
      acc_cnt_d = '0;
      relu_d    = 1'b1;
    end else if (acc_inc && (acc_cnt_q != CNT_MAX)) begin
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end

    err_d = err_q | {acc_inc & (acc_cnt_q == CNT_LEN),
                     f_ofifo_rd & ~ofifo_valid,
                     f_l0_wr & f_l0_rd,
                     f_load & f_execute};
  end

  // Register all decoded outputs and state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q      <= 1'b0;
      execute_q   <= 1'b0;
      l0_wr_q     <= 1'b0;
      l0_rd_q     <= 1'b0;
      ififo_wr_q  <= 1'b0;
      ififo_rd_q  <= 1'b0;
      ofifo_rd_q  <= 1'b0;
      acc_q       <= 1'b0;
      bypass_q    <= 1'b0;
      xmem_cen_q  <= 1'b1;
      xmem_wen_q  <= 1'b1;
      pmem_cen_q  <= 1'b1;
      pmem_wen_q  <= 1'b1;
      xmem_addr_q <= '0;
      pmem_addr_q <= '0;
      phase_q     <= IDLE;
      hold_q      <= 1'b0;
      acc_cnt_q   <= '0;
      relu_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      load_q      <= load_d;
      execute_q   <= execute_d;
      l0_wr_q     <= l0_wr_d;
      l0_rd_q     <= l0_rd_d;
      ififo_wr_q  <= ififo_wr_d;
      ififo_rd_q  <= ififo_rd_d;
      ofifo_rd_q  <= ofifo_rd_d;
      acc_q       <= acc_d;
      bypass_q    <= bypass_d;
      xmem_cen_q  <= xmem_cen_d;
      xmem_wen_q  <= xmem_wen_d;
      pmem_cen_q  <= pmem_cen_d;
      pmem_wen_q  <= pmem_wen_d;
      xmem_addr_q <= xmem_addr_d;
      pmem_addr_q <= pmem_addr_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      acc_cnt_q   <= acc_cnt_d;
      relu_q      <= relu_d;
      err_q       <= err_d;
    end
  end

  assign load_o      = load_q;
  assign execute_o   = execute_q;
  assign l0_wr_o     = l0_wr_q;
  assign l0_rd_o     = l0_rd_q;
  assign ififo_wr_o  = ififo_wr_q;
  assign ififo_rd_o  = ififo_rd_q;
  assign ofifo_rd_o  = ofifo_rd_q;
  assign acc_o       = acc_q;
  assign bypass_o    = bypass_q;
  assign xmem_cen_o  = xmem_cen_q;
  assign xmem_wen_o  = xmem_wen_q;
  assign pmem_cen_o  = pmem_cen_q;
  assign pmem_wen_o  = pmem_wen_q;
  assign xmem_addr_o = xmem_addr_q;
  assign pmem_addr_o = pmem_addr_q;
  assign phase_o     = phase_q;
  assign acc_cnt_o   = acc_cnt_q;
  assign relu_o      = relu_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_inst_decoder.sv
// Directed bench for inst_decoder with a queue of expected outputs per cycle.
module tb_inst_decoder;

  typedef struct packed {
    logic        bypass, acc, cen_p, wen_p;
    logic [10:0] a_p;
    logic        cen_x, wen_x;
    logic [10:0] a_x;
    logic        ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load;
  } inst_t;

  typedef struct {
    logic [8:0]  strobes;
    logic [25:0] mem;
    logic [2:0]  phase;
    logic [3:0]  cnt;
    logic        relu;
    logic [3:0]  err;
  } exp_t;

  localparam logic [2:0] P_IDLE = 3'd0, P_XWR = 3'd1, P_L0FILL = 3'd2,
                         P_EXEC = 3'd4, P_DRAIN = 3'd5, P_ACCUM = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [34:0] inst_v;
  logic        ofifo_valid;
  logic        load_o, execute_o, l0_wr_o, l0_rd_o, ififo_wr_o, ififo_rd_o;
  logic        ofifo_rd_o, acc_o, bypass_o;
  logic        xmem_cen_o, xmem_wen_o, pmem_cen_o, pmem_wen_o;
  logic [10:0] xmem_addr_o, pmem_addr_o;
  logic [2:0]  phase_o;
  logic [3:0]  acc_cnt_o;
  logic        relu_o;
  logic [3:0]  err_o;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  inst_decoder #(.len_kij(9), .inst_bw(35)) dut (
    .clk(clk), .reset(reset), .inst(inst_v), .ofifo_valid(ofifo_valid),
    .load_o(load_o), .execute_o(execute_o), .l0_wr_o(l0_wr_o), .l0_rd_o(l0_rd_o),
    .ififo_wr_o(ififo_wr_o), .ififo_rd_o(ififo_rd_o), .ofifo_rd_o(ofifo_rd_o),
    .acc_o(acc_o), .bypass_o(bypass_o),
    .xmem_cen_o(xmem_cen_o), .xmem_wen_o(xmem_wen_o),
    .pmem_cen_o(pmem_cen_o), .pmem_wen_o(pmem_wen_o),
    .xmem_addr_o(xmem_addr_o), .pmem_addr_o(pmem_addr_o),
    .phase_o(phase_o), .acc_cnt_o(acc_cnt_o), .relu_o(relu_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic inst_t idle_inst();
    inst_t t;
    t = '0;
    t.cen_p = 1'b1; t.wen_p = 1'b1; t.cen_x = 1'b1; t.wen_x = 1'b1;
    return t;
  endfunction

  function automatic logic [8:0] exp_strobes(inst_t t, logic v);
    return {t.load, t.execute, t.l0_wr, t.l0_rd, t.ififo_wr, t.ififo_rd,
            t.ofifo_rd & v, t.acc, t.bypass};
  endfunction

  function automatic logic [25:0] exp_mem(inst_t t);
    logic conflict;
    conflict = !t.cen_p && !t.wen_p && t.acc && !t.bypass;
    return {t.cen_x, t.wen_x, conflict ? 1'b1 : t.cen_p,
            conflict ? 1'b1 : t.wen_p, t.a_x, t.a_p};
  endfunction

  function automatic logic [8:0] obs_strobes();
    return {load_o, execute_o, l0_wr_o, l0_rd_o, ififo_wr_o, ififo_rd_o,
            ofifo_rd_o, acc_o, bypass_o};
  endfunction

  function automatic logic [25:0] obs_mem();
    return {xmem_cen_o, xmem_wen_o, pmem_cen_o, pmem_wen_o, xmem_addr_o, pmem_addr_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".strobes"}, 32'(obs_strobes()), 32'(e.strobes));
    check({tag, ".mem"},     32'(obs_mem()),     32'(e.mem));
    check({tag, ".phase"},   32'(phase_o),       32'(e.phase));
    check({tag, ".acc_cnt"}, 32'(acc_cnt_o),     32'(e.cnt));
    check({tag, ".relu"},    32'(relu_o),        32'(e.relu));
    check({tag, ".err"},     32'(err_o),         32'(e.err));
  endtask

  task automatic check_reset_vals(input string tag);
    exp_t e;
    e.strobes = '0;
    e.mem     = {4'b1111, 22'd0};
    e.phase   = P_IDLE;
    e.cnt     = '0;
    e.relu    = 1'b0;
    e.err     = '0;
    compare(tag, e);
  endtask

  // Drive one instruction, queue its expectation, compare one cycle later
  task automatic step(input string tag, input inst_t t, input logic v,
                      input logic [2:0] ph, input logic [3:0] cnt,
                      input logic relu, input logic [3:0] err);
    exp_t e;
    inst_v      = t;
    ofifo_valid = v;
    e.strobes = exp_strobes(t, v);
    e.mem     = exp_mem(t);
    e.phase   = ph;
    e.cnt     = cnt;
    e.relu    = relu;
    e.err     = err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      compare(tag, e);
    end
  endtask

  initial begin
    inst_t t;
    reset       = 1'b1;
    inst_v      = idle_inst();
    ofifo_valid = 1'b0;
    #12;
    check_reset_vals("reset_init");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Field decode with an xmem read
    t = idle_inst(); t.a_x = 11'h400; t.cen_x = 1'b0; t.wen_x = 1'b1;
    step("xmem_rd", t, 1'b0, P_IDLE, 4'd0, 1'b0, 4'b0000);

    // OFIFO underflow, then a valid read, then one gap held, then idle
    t = idle_inst(); t.ofifo_rd = 1'b1;
    step("underflow", t, 1'b0, P_DRAIN, 4'd0, 1'b0, 4'b0100);
    step("ofifo_rd", t, 1'b1, P_DRAIN, 4'd0, 1'b0, 4'b0100);
    step("gap_hold", idle_inst(), 1'b1, P_DRAIN, 4'd0, 1'b0, 4'b0100);
    step("gap_idle", idle_inst(), 1'b1, P_IDLE, 4'd0, 1'b0, 4'b0100);

    // Strobe conflicts pass through and set sticky flags
    t = idle_inst(); t.load = 1'b1; t.execute = 1'b1;
    step("ld_ex", t, 1'b0, P_EXEC, 4'd0, 1'b0, 4'b0101);
    t = idle_inst(); t.l0_wr = 1'b1; t.l0_rd = 1'b1;
    step("l0_wr_rd", t, 1'b0, P_L0FILL, 4'd0, 1'b0, 4'b0111);
    t = idle_inst(); t.cen_x = 1'b0; t.wen_x = 1'b0; t.a_x = 11'h123; t.ififo_wr = 1'b1;
    step("xmem_wr", t, 1'b0, P_XWR, 4'd0, 1'b0, 4'b0111);

    // pmem write during accumulation is suppressed
    t = idle_inst(); t.cen_p = 1'b0; t.wen_p = 1'b0; t.acc = 1'b1; t.a_p = 11'h055;
    step("wr_acc", t, 1'b0, P_ACCUM, 4'd0, 1'b0, 4'b0111);
    step("wr_acc_end", idle_inst(), 1'b0, P_ACCUM, 4'd0, 1'b1, 4'b0111);
    step("wr_acc_idle", idle_inst(), 1'b0, P_IDLE, 4'd0, 1'b0, 4'b0111);

    // Nine accumulated reads, an acc cycle without a read, then release
    for (int k = 1; k <= 9; k++) begin
      t = idle_inst(); t.acc = 1'b1; t.cen_p = 1'b0; t.wen_p = 1'b1; t.a_p = 11'(k);
      step("acc9", t, 1'b0, P_ACCUM, 4'(k), 1'b0, 4'b0111);
    end
    t = idle_inst(); t.acc = 1'b1;
    step("acc9_nord", t, 1'b0, P_ACCUM, 4'd9, 1'b0, 4'b0111);
    step("acc9_relu", idle_inst(), 1'b0, P_ACCUM, 4'd0, 1'b1, 4'b0111);
    step("acc9_after", idle_inst(), 1'b0, P_IDLE, 4'd0, 1'b0, 4'b0111);

    // Overflow past len_kij and saturation at 15
    for (int k = 1; k <= 17; k++) begin
      t = idle_inst(); t.acc = 1'b1; t.cen_p = 1'b0; t.wen_p = 1'b1;
      step("acc_ovf", t, 1'b0, P_ACCUM, (k > 15) ? 4'd15 : 4'(k), 1'b0,
           (k >= 10) ? 4'b1111 : 4'b0111);
    end
    step("acc_ovf_relu", idle_inst(), 1'b0, P_ACCUM, 4'd0, 1'b1, 4'b1111);
    step("acc_ovf_idle", idle_inst(), 1'b0, P_IDLE, 4'd0, 1'b0, 4'b1111);

    // Single-cycle acc still yields a capture pulse
    t = idle_inst(); t.acc = 1'b1; t.cen_p = 1'b0; t.wen_p = 1'b1;
    step("acc1", t, 1'b0, P_ACCUM, 4'd1, 1'b0, 4'b1111);
    step("acc1_relu", idle_inst(), 1'b0, P_ACCUM, 4'd0, 1'b1, 4'b1111);
    step("acc1_idle", idle_inst(), 1'b0, P_IDLE, 4'd0, 1'b0, 4'b1111);

    // Bypassed write with acc is a real pmem write
    t = idle_inst(); t.bypass = 1'b1; t.acc = 1'b1; t.cen_p = 1'b0; t.wen_p = 1'b0;
    t.a_p = 11'h7ff;
    step("bypass_wr", t, 1'b0, P_DRAIN, 4'd0, 1'b0, 4'b1111);
    step("bypass_relu", idle_inst(), 1'b0, P_DRAIN, 4'd0, 1'b1, 4'b1111);
    step("bypass_idle", idle_inst(), 1'b0, P_IDLE, 4'd0, 1'b0, 4'b1111);

    // Reset in the middle of an accumulation
    for (int k = 1; k <= 5; k++) begin
      t = idle_inst(); t.acc = 1'b1; t.cen_p = 1'b0; t.wen_p = 1'b1;
      step("acc5", t, 1'b0, P_ACCUM, 4'(k), 1'b0, 4'b1111);
    end
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("reset_async");
    inst_v = idle_inst();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_vals("reset_held");
    reset = 1'b0;
    step("post_rst_idle", idle_inst(), 1'b0, P_IDLE, 4'd0, 1'b0, 4'b0000);
    t = idle_inst(); t.a_x = 11'h2aa; t.cen_x = 1'b0; t.wen_x = 1'b1; t.l0_rd = 1'b1;
    step("post_rst_dec", t, 1'b0, P_IDLE, 4'd0, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_decoder.md
INST_DECODER -- requirements
Module: inst_decoder

Interface
REQ-001 SHALL have parameter len_kij, default 9, meaning the number of PSUMs accumulated per output position.
REQ-002 SHALL have parameter inst_bw, default 35, meaning the width of the instruction word.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port inst, input, 35, the instruction word: [34] bypass, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-006 SHALL have port ofifo_valid, input, 1, meaning the OFIFO holds at least one entry.
REQ-007 SHALL have outputs load_o, execute_o, l0_wr_o, l0_rd_o, ififo_wr_o, ififo_rd_o, ofifo_rd_o, acc_o, bypass_o, each 1 bit, meaning the registered, decoded strobes.
REQ-008 SHALL have outputs xmem_cen_o, xmem_wen_o, pmem_cen_o, pmem_wen_o, each 1 bit and active-low, plus xmem_addr_o and pmem_addr_o, each 11 bits.
REQ-009 SHALL have output phase_o, 3 bits, meaning the current FSM phase encoding.
REQ-010 SHALL have output acc_cnt_o, 4 bits, meaning the number of accumulation reads issued for the current output.
REQ-011 SHALL have output relu_o, 1 bit, a one-cycle pulse requesting ReLU/output capture.
REQ-012 SHALL have output err_o, 4 bits, sticky error flags: [0] load&execute, [1] l0_wr&l0_rd, [2] ofifo underflow, [3] acc count overflow.

Function
REQ-013 SHALL register every decoded output one cycle after inst is sampled; inst to output latency is exactly 1 cycle.
REQ-014 SHALL gate ofifo_rd_o: ofifo_rd_o = inst[6] AND ofifo_valid, sampled in the same cycle; inst[6]=1 with ofifo_valid=0 gives ofifo_rd_o=0 next cycle and sets err_o[2].
REQ-015 SHALL force pmem_cen_o=1 and pmem_wen_o=1 in a cycle where a write is requested (CEN_pmem=0, WEN_pmem=0) with bypass=0 and acc=1; this conflict SHALL be treated as no access.
REQ-016 SHALL set err_o[0] when load and execute are both 1, and set err_o[1] when l0_wr and l0_rd are both 1; the strobes SHALL still pass through unchanged.
REQ-017 SHALL implement the FSM states IDLE=0, XWR=1, L0FILL=2, LOAD=3, EXEC=4, DRAIN=5, ACCUM=6.
REQ-018 SHALL select the next state from the sampled inst using this priority: execute -> EXEC; load -> LOAD; l0_wr -> L0FILL; xmem write (CEN_xmem=0, WEN_xmem=0) -> XWR; ofifo_rd or a pmem write -> DRAIN; acc=1 -> ACCUM; otherwise IDLE.
REQ-019 SHALL hold the current state for at most 1 cycle when no strobe is set, then go to IDLE, so that single idle gaps inside a phase are tolerated.
REQ-020 SHALL increment acc_cnt on each cycle with acc=1 and a pmem read (CEN_pmem=0, WEN_pmem=1); acc_cnt SHALL saturate at 15.
REQ-021 SHALL set err_o[3] when an increment is attempted with acc_cnt already equal to len_kij.
REQ-022 SHALL pulse relu_o for exactly one cycle on the 1->0 transition of registered acc_o, then clear acc_cnt to 0 in that same cycle.
REQ-023 SHALL, when acc rises and falls in the same sampled cycle (a one-cycle acc), still produce the relu_o pulse on the following cycle.
REQ-024 SHALL never clear the err_o bits except on reset.

Reset
REQ-025 SHALL, while reset=1, immediately (asynchronously) drive all strobes to 0, all CEN/WEN outputs to 1, both addresses to 0, phase_o to IDLE, acc_cnt_o to 0, relu_o to 0 and err_o to 0.
REQ-026 SHALL, when reset asserts mid-operation (for example during ACCUM with acc_cnt=5), abandon the operation with no relu_o pulse, and SHALL decode normally from the first rising edge after reset deasserts.

Verification
REQ-027 SHALL verify field decode: inst with A_xmem=0x400, CEN_xmem=0, WEN_xmem=1 -> next cycle xmem_addr_o=0x400, xmem_cen_o=0, xmem_wen_o=1, phase_o=IDLE.
REQ-028 SHALL verify underflow: ofifo_rd=1 with ofifo_valid=0 -> ofifo_rd_o=0 and err_o=4'b0100, with the flag held after ofifo_valid rises.
REQ-029 SHALL verify accumulation: 9 cycles of acc=1 with pmem reads, then 1 cycle of acc=1 with CEN_pmem=1, then acc=0 -> acc_cnt_o reaches 9, relu_o pulses once, and acc_cnt_o returns to 0.
REQ-030 SHALL verify the conflict case: load=1, execute=1 -> phase_o=EXEC and err_o[0]=1, with both load_o and execute_o equal to 1.
REQ-031 SHALL verify the write/acc conflict: CEN_pmem=0, WEN_pmem=0, acc=1, bypass=0 -> pmem_cen_o=1 and pmem_wen_o=1.
REQ-032 SHALL verify reset: reset asserted during ACCUM with acc_cnt=5 -> all outputs take reset values with no clock edge, and no relu_o pulse occurs.
